uart_tx_frame: RTL

Parametrised UART transmit framer. It takes one parallel word through a valid/ready handshake and serialises it LSB-first on `txd` as start bit, data bits, optional parity bit and 1–2 stop bits. Each bit lasts exactly `CLK_DIV` clocks. It is the successor to the fixed 8N1 transmitter in the UART stage and sits between the application/FIFO side and the board TX pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx_frame.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and parity-mode constants.
// Used by the transmit framer and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   localparam int unsigned BAUD_CNT_W = 20;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: counts 0..CLK_DIV-1 while enabled and flags the last cycle.
// The counter is held at zero while en is low.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam logic [BAUD_CNT_W-1:0] CntLast = BAUD_CNT_W'(CLK_DIV - 1);

   logic [BAUD_CNT_W-1:0] cnt_q;

   assign tick = en && (cnt_q == CntLast);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (!en || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + BAUD_CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 5208,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned PARITY_MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int unsigned CntW = 4;
   localparam logic [CntW-1:0] DataLast = CntW'(DATA_BITS - 1);
   localparam logic [CntW-1:0] StopLast = CntW'(STOP_BITS - 1);

   uart_state_e          state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [CntW-1:0]      bit_cnt_q;
   logic                 tick;
   logic                 par_bit;

`ifdef UART_TX_PARITY_EN
   localparam bit ParOn  = (PARITY_MODE == PAR_ODD) || (PARITY_MODE == PAR_EVEN);
   localparam bit ParInv = (PARITY_MODE == PAR_ODD);
   logic par_q;
   assign par_bit = par_q;
`else
   // Parity never sent in this build; PARITY_MODE only kept for a uniform parameter list.
   localparam bit ParOn = 1'b0 && (PARITY_MODE != PAR_NONE);
   assign par_bit = 1'b1;
`endif

   assign tx_ready = (state_q == IDLE);
   assign tx_busy  = (state_q != IDLE);

   uart_baud_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .en   (tx_busy),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         txd       <= 1'b1;
         tx_done   <= 1'b0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (tx_valid) begin
                  state_q   <= START;
                  txd       <= 1'b0;
                  shift_q   <= tx_data;
                  bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                  par_q     <= (^tx_data) ^ ParInv;
`endif
               end
            end
            START: begin
               if (tick) begin
                  state_q <= DATA;
                  txd     <= shift_q[0];
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_cnt_q == DataLast) begin
                     bit_cnt_q <= '0;
                     if (ParOn) begin
                        state_q <= PARITY;
                        txd     <= par_bit;
                     end else begin
                        state_q <= STOP;
                        txd     <= 1'b1;
                     end
                  end else begin
                     // Bit 1 becomes the new LSB as the register shifts this edge.
                     txd       <= shift_q[1];
                     shift_q   <= shift_q >> 1;
                     bit_cnt_q <= bit_cnt_q + CntW'(1);
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  state_q <= STOP;
                  txd     <= 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  if (bit_cnt_q == StopLast) begin
                     state_q   <= IDLE;
                     tx_done   <= 1'b1;
                     bit_cnt_q <= '0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CntW'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               txd     <= 1'b1;
            end
         endcase
      end
   end

endmodule
